udp_rx_decoder_param: RTL and testbench

- Parametrised UDP receive decoder. Sits between the IPv4 receive decoder and the UDP payload FIFO/socket demux.
- Accepts the IP datagram payload as a beat stream DATA_BYTES wide with a valid qualifier. Extracts the UDP header and streams the payload out with per-byte keep and last markers.
- Verifies the pseudo-header checksum and the length consistency.
- Returns to idle after each datagram, so no reset is needed between packets.

---
 rtl/udp_rx_decoder_param.sv | 162 ++++++++++++++++
 tb/tb_udp_rx_decoder_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_decoder_param.sv
// UDP receive decoder: strips the 8-byte UDP header, streams the payload with
// byte keeps, and checks the pseudo-header checksum and UDP/IP length agreement.
module udp_rx_decoder_param #(
  parameter int DATA_BYTES = 4,
  parameter bit CHECK_LEN  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [31:0]             dest_ip,
  input  logic [31:0]             src_ip,
  input  logic [15:0]             len_ip,
  input  logic [8*DATA_BYTES-1:0] in_data,
  input  logic                    in_valid,
  output logic [15:0]             src_port,
  output logic [15:0]             dest_port,
  output logic [15:0]             len_udp,
  output logic [8*DATA_BYTES-1:0] out_data,
  output logic [DATA_BYTES-1:0]   out_keep,
  output logic                    out_valid,
  output logic                    out_last,
  output logic                    fin,
  output logic                    ok,
  output logic                    err_len,
  output logic                    err_csum
);
  localparam int W  = 8 * DATA_BYTES;
  localparam int NW = DATA_BYTES / 2;
  localparam int HB = 8 / DATA_BYTES;
  localparam logic [15:0] DB16 = 16'(DATA_BYTES);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

  state_t      state;
  logic        hdr_cnt;
  logic [W-1:0] hdr_q;
  logic [15:0] acc;
  logic [15:0] len_ip_q;
  logic [15:0] bytes_left;
  logic        no_csum;
  logic        short_len;

  logic [DATA_BYTES-1:0] keep_c;
  logic [W-1:0]          data_m;
  logic [19:0]           beat_sum;
  logic [19:0]           seed_sum;
  logic [63:0]           hdr_next;
  logic                  last_hdr;
  logic                  el_c;
  logic                  ec_c;

  // Two end-around folds reduce any sum of up to 16 words to 16 bits.
  function automatic logic [15:0] fold(input logic [19:0] s);
    logic [16:0] t;
    t = {1'b0, s[15:0]} + {13'd0, s[19:16]};
    return t[15:0] + {15'd0, t[16]};
  endfunction

  always_comb begin
    keep_c = '0;
    for (int i = 0; i < DATA_BYTES; i++)
      if (state == HDR || 16'(i) < bytes_left) keep_c[DATA_BYTES-1-i] = 1'b1;
    data_m = '0;
    for (int i = 0; i < DATA_BYTES; i++)
      data_m[8*i +: 8] = keep_c[i] ? in_data[8*i +: 8] : 8'h00;
    beat_sum = {4'd0, acc};
    for (int j = 0; j < NW; j++)
      beat_sum = beat_sum + {4'd0, data_m[W-1-16*j -: 16]};
    seed_sum = {4'd0, src_ip[31:16]} + {4'd0, src_ip[15:0]} +
               {4'd0, dest_ip[31:16]} + {4'd0, dest_ip[15:0]} +
               20'h00011 + {4'd0, len_ip};
  end

  // Whole header is visible on its final beat: earlier beat in hdr_q, current in in_data.
  assign hdr_next = 64'({hdr_q, in_data});
  assign last_hdr = (HB == 1) || hdr_cnt;
  assign el_c     = (CHECK_LEN && (len_udp != len_ip_q)) || short_len;
  assign ec_c     = !no_csum && (acc != 16'hFFFF);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      hdr_cnt    <= 1'b0;
      hdr_q      <= '0;
      acc        <= '0;
      len_ip_q   <= '0;
      bytes_left <= '0;
      no_csum    <= 1'b0;
      short_len  <= 1'b0;
      src_port   <= '0;
      dest_port  <= '0;
      len_udp    <= '0;
      out_data   <= '0;
      out_keep   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      fin        <= 1'b0;
      ok         <= 1'b0;
      err_len    <= 1'b0;
      err_csum   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      fin       <= 1'b0;
      ok        <= 1'b0;
      err_len   <= 1'b0;
      err_csum  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          len_ip_q   <= len_ip;
          acc        <= fold(seed_sum);
          no_csum    <= 1'b0;
          hdr_cnt    <= 1'b0;
          bytes_left <= '0;
          src_port   <= '0;
          dest_port  <= '0;
          len_udp    <= '0;
          short_len  <= (len_ip < 16'd8);
          state      <= (len_ip < 16'd8) ? DONE : HDR;
        end
        HDR: if (in_valid) begin
          acc     <= fold(beat_sum);
          hdr_q   <= in_data;
          hdr_cnt <= ~hdr_cnt;
          if (last_hdr) begin
            src_port  <= hdr_next[63:48];
            dest_port <= hdr_next[47:32];
            len_udp   <= hdr_next[31:16];
            no_csum   <= (hdr_next[15:0] == 16'h0000);
            if (len_ip_q == 16'd8) begin
              state <= DONE;
            end else begin
              bytes_left <= len_ip_q - 16'd8;
              state      <= DATA;
            end
          end
        end
        DATA: if (in_valid) begin
          acc       <= fold(beat_sum);
          out_valid <= 1'b1;
          out_data  <= data_m;
          out_keep  <= keep_c;
          if (bytes_left <= DB16) begin
            out_last   <= 1'b1;
            bytes_left <= '0;
            state      <= DONE;
          end else begin
            bytes_left <= bytes_left - DB16;
          end
        end
        DONE: begin
          fin      <= 1'b1;
          err_len  <= el_c;
          err_csum <= ec_c;
          ok       <= !el_c && !ec_c;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_rx_decoder_param.sv
// Scoreboard bench: three decoders (4-byte, 8-byte, 4-byte without length check)
// driven one at a time from a directed sequence; a negedge monitor pops expectations.
module tb_udp_rx_decoder_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] src_ip, dest_ip;
  logic [15:0] len_ip;
  logic        start_a, start_b, start_c, vld_a, vld_b, vld_c;
  logic [31:0] d32;
  logic [63:0] d64;

  logic [15:0] a_sp, a_dp, a_lu, b_sp, b_dp, b_lu, c_sp, c_dp, c_lu;
  logic [31:0] a_data, c_data;
  logic [63:0] b_data;
  logic [3:0]  a_keep, c_keep;
  logic [7:0]  b_keep;
  logic a_valid, a_last, a_fin, a_ok, a_el, a_ec;
  logic b_valid, b_last, b_fin, b_ok, b_el, b_ec;
  logic c_valid, c_last, c_fin, c_ok, c_el, c_ec;

  udp_rx_decoder_param #(.DATA_BYTES(4), .CHECK_LEN(1'b1)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .dest_ip(dest_ip), .src_ip(src_ip),
    .len_ip(len_ip), .in_data(d32), .in_valid(vld_a), .src_port(a_sp), .dest_port(a_dp),
    .len_udp(a_lu), .out_data(a_data), .out_keep(a_keep), .out_valid(a_valid),
    .out_last(a_last), .fin(a_fin), .ok(a_ok), .err_len(a_el), .err_csum(a_ec));
  udp_rx_decoder_param #(.DATA_BYTES(8), .CHECK_LEN(1'b1)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .dest_ip(dest_ip), .src_ip(src_ip),
    .len_ip(len_ip), .in_data(d64), .in_valid(vld_b), .src_port(b_sp), .dest_port(b_dp),
    .len_udp(b_lu), .out_data(b_data), .out_keep(b_keep), .out_valid(b_valid),
    .out_last(b_last), .fin(b_fin), .ok(b_ok), .err_len(b_el), .err_csum(b_ec));
  udp_rx_decoder_param #(.DATA_BYTES(4), .CHECK_LEN(1'b0)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .dest_ip(dest_ip), .src_ip(src_ip),
    .len_ip(len_ip), .in_data(d32), .in_valid(vld_c), .src_port(c_sp), .dest_port(c_dp),
    .len_udp(c_lu), .out_data(c_data), .out_keep(c_keep), .out_valid(c_valid),
    .out_last(c_last), .fin(c_fin), .ok(c_ok), .err_len(c_el), .err_csum(c_ec));

  typedef struct { int inst; logic [63:0] data; logic [7:0] keep; logic last; } beat_t;
  typedef struct { int inst; bit hdr; logic [15:0] sp, dp, lu; logic ok, el, ec; } fin_t;

  beat_t       bq[$];
  fin_t        fq[$];
  logic [7:0]  pl[$];
  logic [63:0] tx[$];
  int n_pass = 0, n_total = 0, n_fail = 0, fin_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int k, input logic st, input logic v, input logic [63:0] d);
    start_a = st && k == 0; start_b = st && k == 1; start_c = st && k == 2;
    vld_a   = v && k == 0;  vld_b   = v && k == 1;  vld_c   = v && k == 2;
    d64 = d;
    d32 = d[31:0];
  endtask

  function automatic logic get_fin(input int k);
    return (k == 0) ? a_fin : (k == 1) ? b_fin : c_fin;
  endfunction
  function automatic logic get_last(input int k);
    return (k == 0) ? a_last : (k == 1) ? b_last : c_last;
  endfunction

  function automatic logic [15:0] add1(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + 16'(s[16]);
  endfunction

  // Builds wire beats from header + pl, and queues the expected output beats and fin.
  task automatic prep(input int k, input logic [15:0] len, input logic [15:0] sp,
                      input logic [15:0] dp, input logic [15:0] lu, input logic [15:0] cs_in,
                      input bit auto_cs, input bit hdr, input logic eok, input logic eel,
                      input logic eec);
    int db;
    logic [15:0] s, cs;
    logic [7:0] by[$];
    logic [63:0] v;
    logic [7:0] kp;
    db = (k == 1) ? 8 : 4;
    len_ip = len;
    cs = cs_in;
    if (auto_cs) begin
      s = 16'h0;
      s = add1(s, src_ip[31:16]); s = add1(s, src_ip[15:0]);
      s = add1(s, dest_ip[31:16]); s = add1(s, dest_ip[15:0]);
      s = add1(s, 16'h0011); s = add1(s, len);
      s = add1(s, sp); s = add1(s, dp); s = add1(s, lu);
      for (int i = 0; i < pl.size(); i += 2)
        s = add1(s, {pl[i], (i + 1 < pl.size()) ? pl[i+1] : 8'h00});
      cs = ~s;
      if (cs == 16'h0) cs = 16'hFFFF;
    end
    tx = {};
    if (len >= 16'd8) begin
      by = {sp[15:8], sp[7:0], dp[15:8], dp[7:0], lu[15:8], lu[7:0], cs[15:8], cs[7:0]};
      foreach (pl[i]) by.push_back(pl[i]);
      while (by.size() % db != 0) by.push_back(8'hA5);
      for (int i = 0; i < by.size(); i += db) begin
        v = '0;
        for (int j = 0; j < db; j++) v = (v << 8) | 64'(by[i+j]);
        tx.push_back(v);
      end
    end
    for (int i = 0; i < pl.size(); i += db) begin
      v = '0; kp = '0;
      for (int j = 0; j < db; j++) begin
        v = v << 8; kp = kp << 1;
        if (i + j < pl.size()) begin v = v | 64'(pl[i+j]); kp = kp | 8'h01; end
      end
      bq.push_back('{inst: k, data: v, keep: kp, last: (i + db >= pl.size())});
    end
    fq.push_back('{inst: k, hdr: hdr, sp: sp, dp: dp, lu: lu, ok: eok, el: eel, ec: eec});
  endtask

  task automatic send(input int k, input int gap);
    int lat;
    drive(k, 1'b1, 1'b0, '0); tick(); drive(k, 1'b0, 1'b0, '0);
    foreach (tx[i]) begin
      repeat (gap) tick();
      drive(k, 1'b0, 1'b1, tx[i]); tick(); drive(k, 1'b0, 1'b0, '0);
    end
    lat = 1;
    if (pl.size() > 0) chk("out_last_latency", 64'(get_last(k)), 64'd1);
    while (!get_fin(k) && lat < 20) begin tick(); lat++; end
    chk("fin_latency", 64'(lat), 64'd2);
  endtask

  task automatic mon_beat(input int k, input logic [63:0] d, input logic [7:0] kp, input logic l);
    beat_t e;
    chk("beat_pending", 64'(bq.size() > 0), 64'd1);
    if (bq.size() > 0) begin
      e = bq.pop_front();
      chk("beat_inst", 64'(k), 64'(e.inst));
      chk("out_data", d, e.data);
      chk("out_keep", 64'(kp), 64'(e.keep));
      chk("out_last", 64'(l), 64'(e.last));
    end
  endtask

  task automatic mon_fin(input int k, input logic [15:0] sp, input logic [15:0] dp,
                         input logic [15:0] lu, input logic o, input logic el, input logic ec);
    fin_t e;
    fin_cnt++;
    chk("fin_pending", 64'(fq.size() > 0), 64'd1);
    if (fq.size() > 0) begin
      e = fq.pop_front();
      chk("fin_inst", 64'(k), 64'(e.inst));
      chk("ok", 64'(o), 64'(e.ok));
      chk("err_len", 64'(el), 64'(e.el));
      if (e.hdr) begin
        chk("ports_len", {16'h0, sp, dp, lu}, {16'h0, e.sp, e.dp, e.lu});
        chk("err_csum", 64'(ec), 64'(e.ec));
      end
    end
  endtask

  always @(negedge clk) begin
    if (a_valid) mon_beat(0, 64'(a_data), 8'(a_keep), a_last);
    if (b_valid) mon_beat(1, b_data, b_keep, b_last);
    if (c_valid) mon_beat(2, 64'(c_data), 8'(c_keep), c_last);
    if (a_fin) mon_fin(0, a_sp, a_dp, a_lu, a_ok, a_el, a_ec);
    if (b_fin) mon_fin(1, b_sp, b_dp, b_lu, b_ok, b_el, b_ec);
    if (c_fin) mon_fin(2, c_sp, c_dp, c_lu, c_ok, c_el, c_ec);
  end

  task automatic test1(input int k, input logic [15:0] cs, input logic eok, input logic eec);
    src_ip = 32'h0A000001; dest_ip = 32'h0A000002;
    pl = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    prep(k, 16'd12, 16'h1234, 16'h5678, 16'd12, cs, 1'b0, 1'b1, eok, 1'b0, eec);
    send(k, 0);
  endtask

  initial begin
    int fc0;
    reset = 1'b0; src_ip = '0; dest_ip = '0; len_ip = '0;
    drive(0, 1'b0, 1'b0, '0);
    repeat (3) tick();
    chk("rst_a_hdr", {a_sp, a_dp, a_lu}, 64'd0);
    chk("rst_a_out", {a_data, a_keep, a_valid, a_last, a_fin, a_ok, a_el, a_ec}, 64'd0);
    chk("rst_b_out", {b_keep, b_valid, b_last, b_fin, b_ok, b_el, b_ec}, 64'd0);
    reset = 1'b1; tick();

    test1(0, 16'hE589, 1'b1, 1'b0);
    test1(0, 16'hE588, 1'b0, 1'b1);
    test1(0, 16'h0000, 1'b1, 1'b0);

    // Odd length, no checksum; filler in unkept bytes must be zeroed; then with gaps.
    for (int g = 0; g < 3; g += 2) begin
      pl = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hAB};
      prep(0, 16'd13, 16'h1234, 16'h5678, 16'd13, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      send(0, g);
    end
    // Odd length with a real checksum exercises the zero padding in the sum.
    pl = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hAB};
    prep(0, 16'd13, 16'h1234, 16'h5678, 16'd13, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    send(0, 1);

    // 8-byte beats, back to back.
    test1(1, 16'hE589, 1'b1, 1'b0);
    src_ip = 32'hC0A80001; dest_ip = 32'hC0A800FE;
    pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    prep(1, 16'd20, 16'h0400, 16'h0035, 16'd20, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    send(1, 0);

    // Length mismatch with and without the length check, header-only, and short length.
    src_ip = 32'h0A000001; dest_ip = 32'h0A000002;
    pl = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    prep(0, 16'd12, 16'h1234, 16'h5678, 16'd16, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    send(0, 0);
    prep(2, 16'd12, 16'h1234, 16'h5678, 16'd16, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send(2, 0);
    pl = {};
    prep(0, 16'd8, 16'h0007, 16'h0009, 16'd8, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    send(0, 0);
    prep(0, 16'd6, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(0, 0);

    // Reset after the first of two payload beats: drop the datagram silently.
    pl = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    prep(0, 16'd16, 16'h1111, 16'h2222, 16'd16, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    void'(bq.pop_back());
    void'(fq.pop_back());
    drive(0, 1'b1, 1'b0, '0); tick(); drive(0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b0, 1'b1, tx[i]); tick(); drive(0, 1'b0, 1'b0, '0);
    end
    fc0 = fin_cnt;
    reset = 1'b0; tick();
    chk("midrst_hdr", {a_sp, a_dp, a_lu}, 64'd0);
    chk("midrst_out", {a_data, a_keep, a_valid, a_last, a_fin, a_ok, a_el, a_ec}, 64'd0);
    repeat (3) tick();
    reset = 1'b1; repeat (3) tick();
    chk("midrst_no_fin", 64'(fin_cnt), 64'(fc0));
    test1(0, 16'hE589, 1'b1, 1'b0);

    repeat (3) tick();
    chk("beat_queue_drained", 64'(bq.size()), 64'd0);
    chk("fin_queue_drained", 64'(fq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
